// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the boot loader.
// The slave modport is the loader side; master is the stream source / RAM side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int D_WIDTH    = 32
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_waddr;
  logic [D_WIDTH-1:0]    imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: parses a framed byte stream (count, payload,
// XOR checksum), writes each word to IMEM and releases the CPU once the image verifies.
module imem_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int D_WIDTH    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                cpu_hold,
  output logic                done,
  output logic                err,
  output logic [ADDR_WIDTH:0] words_written
);
  localparam int MEM_DEPTH      = 1 << ADDR_WIDTH;
  localparam int BYTES_PER_WORD = D_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] WW_ONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;

  state_t              state;
  logic [7:0]          cnt_hi;
  logic [7:0]          csum;
  logic [1:0]          byte_cnt;
  logic [23:0]         asm_r;
  logic [ADDR_WIDTH:0] n_words;
  logic                accept;
  logic [15:0]         n_hdr;

  assign accept = bus.in_valid && bus.in_ready;
  assign n_hdr  = {cnt_hi, bus.in_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      bus.in_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_waddr <= '0;
      bus.imem_wdata <= '0;
      cpu_hold       <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
      words_written  <= '0;
      cnt_hi         <= '0;
      csum           <= '0;
      byte_cnt       <= '0;
      asm_r          <= '0;
      n_words        <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state          <= HDR0;
            bus.in_ready   <= 1'b1;
            cpu_hold       <= 1'b1;
            done           <= 1'b0;
            err            <= 1'b0;
            words_written  <= '0;
            bus.imem_waddr <= '0;
            csum           <= '0;
            byte_cnt       <= '0;
          end
        end
        HDR0: begin
          if (accept) begin
            cnt_hi <= bus.in_data;
            state  <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            if ({16'd0, n_hdr} > 32'(MEM_DEPTH)) begin
              state        <= ERR;
              err          <= 1'b1;
              bus.in_ready <= 1'b0;
            end else if (n_hdr == 16'd0) begin
              state <= CHK;
            end else begin
              state   <= DATA;
              n_words <= n_hdr[ADDR_WIDTH:0];
            end
          end
        end
        DATA: begin
          if (accept) begin
            csum     <= csum ^ bus.in_data;
            byte_cnt <= byte_cnt + 2'd1;
            asm_r    <= {asm_r[15:0], bus.in_data};
            // words_written doubles as the write address; it counts completed words
            if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
              bus.imem_we    <= 1'b1;
              bus.imem_wdata <= {asm_r, bus.in_data};
              bus.imem_waddr <= words_written[ADDR_WIDTH-1:0];
              words_written  <= words_written + WW_ONE;
              if (words_written + WW_ONE == n_words)
                state <= CHK;
            end
          end
        end
        CHK: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            if (bus.in_data == csum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule
